// File: rtl/run_sequencer_pkg.sv
// Shared types and width helpers for the run sequencer.
package run_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDrain,
    StHold
  } seq_state_e;

  // Counter/index widths never collapse to zero bits.
  function automatic int unsigned owner_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Request/grant and buffer start/drain handshake bundle.
interface run_sequencer_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            sink_start;
  logic            source_valid;
  logic            source_eop;

  modport master (
    output req,
    output source_valid,
    output source_eop,
    input  grant,
    input  sink_start
  );

  modport slave (
    input  req,
    input  source_valid,
    input  source_eop,
    output grant,
    output sink_start
  );
endinterface

// File: rtl/run_sequencer_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant pulse and winner index.
module run_sequencer_rr_arbiter
  import run_sequencer_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = owner_width(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  input  logic            enable_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   index_o
);

  logic [IW-1:0] last_q;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          any;

  // Search starts one past the last winner and wraps.
  always_comb begin
    win  = last_q;
    cand = last_q;
    any  = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(last_q) + i) % NREQ);
      if (!any && req_i[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_o <= '0;
      index_o <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      grant_o <= '0;
      if (enable_i && any) begin
        grant_o <= NREQ'(1) << win;
        index_o <= win;
        last_q  <= win;
      end
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Run-level controller: arbitrates requesters, starts a buffer fill, tracks drain, enforces hold-off.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter  int unsigned NSINK   = 4,
  parameter  int unsigned LENGTH  = 256,
  parameter  int unsigned NREQ    = 2,
  parameter  int unsigned HOLDOFF = 16,
  parameter  int unsigned TIMEOUT = 4096,
  parameter  int unsigned CWIDTH  = 16,
  localparam int unsigned OW      = owner_width(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  run_sequencer_if.slave    bus,
  output logic              busy,
  output logic              run_done,
  output logic [CWIDTH-1:0] run_id,
  output logic [OW-1:0]     owner,
  output logic              error
);

  localparam int unsigned FW = cnt_width(LENGTH);
  localparam int unsigned EW = $clog2(NSINK + 1);
  localparam int unsigned WW = cnt_width(TIMEOUT);
  localparam int unsigned HW = cnt_width(HOLDOFF);

  localparam logic [FW-1:0] FillLast = FW'(LENGTH - 1);
  localparam logic [EW-1:0] EopLast  = EW'(NSINK - 1);
  localparam logic [WW-1:0] WdogLast = WW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HoldLast = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  seq_state_e        state_q, state_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [EW-1:0]     eop_q, eop_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic [CWIDTH-1:0] run_id_q, run_id_d;
  logic              error_q, error_d;
  logic              eop_hit;

  assign eop_hit = bus.source_valid & bus.source_eop;

  run_sequencer_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i    (clk),
    .rst_ni   (reset),
    .req_i    (bus.req),
    .enable_i (state_q == StIdle),
    .grant_o  (bus.grant),
    .index_o  (owner)
  );

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    eop_d    = eop_q;
    wdog_d   = wdog_q;
    hold_d   = hold_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    run_id_d = run_id_q;
    error_d  = error_q;

    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d = StFill;
          fill_d  = '0;
          start_d = 1'b1;
        end
      end
      StFill: begin
        if (fill_q == FillLast) begin
          state_d = StDrain;
          eop_d   = '0;
          wdog_d  = '0;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      StDrain: begin
        // Completion wins over a timeout landing on the same cycle.
        if (eop_hit && eop_q == EopLast) begin
          done_d   = 1'b1;
          run_id_d = run_id_q + 1'b1;
          hold_d   = '0;
          state_d  = (HOLDOFF == 0) ? StIdle : StHold;
        end else if (wdog_q == WdogLast) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (eop_hit) eop_d = eop_q + 1'b1;
        end
      end
      StHold: begin
        if (hold_q == HoldLast) state_d = StIdle;
        else                    hold_d  = hold_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Buffer must stay silent until the fill has completed.
    if ((state_q == StIdle || state_q == StFill) && bus.source_valid) error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      fill_q   <= '0;
      eop_q    <= '0;
      wdog_q   <= '0;
      hold_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      run_id_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      eop_q    <= eop_d;
      wdog_q   <= wdog_d;
      hold_q   <= hold_d;
      start_q  <= start_d;
      done_q   <= done_d;
      run_id_q <= run_id_d;
      error_q  <= error_d;
    end
  end

  assign bus.sink_start = start_q;
  assign busy           = (state_q != StIdle);
  assign run_done       = done_q;
  assign run_id         = run_id_q;
  assign error          = error_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed/randomized bench for run_sequencer against a transaction-level expectation model.
module tb_run_sequencer;

  localparam int unsigned NSINK   = 4;
  localparam int unsigned LENGTH  = 256;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned HOLDOFF = 16;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CWIDTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              busy;
  logic              run_done;
  logic [CWIDTH-1:0] run_id;
  logic [0:0]        owner;
  logic              error;

  run_sequencer_if #(.NREQ(NREQ)) bus ();

  run_sequencer #(
    .NSINK   (NSINK),
    .LENGTH  (LENGTH),
    .NREQ    (NREQ),
    .HOLDOFF (HOLDOFF),
    .TIMEOUT (TIMEOUT),
    .CWIDTH  (CWIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .busy     (busy),
    .run_done (run_done),
    .run_id   (run_id),
    .owner    (owner),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Expectation model state
  int last_win = NREQ - 1;
  int exp_runs = 0;
  bit exp_err  = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int i = 1; i <= int'(NREQ); i++) begin
      int c;
      c = (last + i) % int'(NREQ);
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_grant"}, 32'(bus.grant), 32'd0);
    check({pfx, "_sink_start"}, 32'(bus.sink_start), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_run_done"}, 32'(run_done), 32'd0);
    check({pfx, "_run_id"}, 32'(run_id), 32'd0);
    check({pfx, "_owner"}, 32'(owner), 32'd0);
    check({pfx, "_error"}, 32'(error), 32'd0);
  endtask

  // One run: grant, LENGTH fill cycles, NSINK eops (or a stall), then hold-off.
  task automatic do_run(input logic [NREQ-1:0] rq, input bit hold_req, input int stall_after,
                        input bit valid_in_fill);
    int w;
    int fault_at;
    int drain_cyc;
    int done_at;
    int gap;
    bit bad;
    w = rr_pick(rq, last_win);
    bus.req = rq;
    tick();
    if (!hold_req) bus.req = '0;
    check("grant", 32'(bus.grant), 32'(1 << w));
    check("sink_start", 32'(bus.sink_start), 32'd1);
    check("owner", 32'(owner), 32'(w));
    check("busy_start", 32'(busy), 32'd1);
    last_win = w;

    fault_at = valid_in_fill ? int'($urandom_range(1, LENGTH - 2)) : -1;
    bad = 1'b0;
    for (int i = 1; i < int'(LENGTH); i++) begin
      bus.source_valid = (i == fault_at);
      bus.source_eop   = 1'b0;
      tick();
      if (bus.grant != '0 || bus.sink_start || !busy || run_done) bad = 1'b1;
    end
    bus.source_valid = 1'b0;
    if (valid_in_fill) exp_err = 1'b1;
    check("fill_quiet", 32'(bad), 32'd0);
    check("fill_error", 32'(error), 32'(exp_err));
    tick();

    drain_cyc = 0;
    bad = 1'b0;
    for (int k = 0; k < int'(NSINK); k++) begin
      if (k == stall_after) break;
      gap = int'($urandom_range(0, 4));
      for (int g = 0; g < gap; g++) begin
        bus.source_valid = 1'($urandom_range(0, 1));
        bus.source_eop   = 1'b0;
        tick();
        drain_cyc++;
        if (run_done) bad = 1'b1;
      end
      bus.source_valid = 1'b1;
      bus.source_eop   = 1'b1;
      tick();
      drain_cyc++;
      if (k < int'(NSINK) - 1 && run_done) bad = 1'b1;
    end
    bus.source_valid = 1'b0;
    bus.source_eop   = 1'b0;

    if (stall_after < 0) begin
      exp_runs = (exp_runs + 1) % (1 << CWIDTH);
      check("no_early_done", 32'(bad), 32'd0);
      check("run_done", 32'(run_done), 32'd1);
      check("run_id", 32'(run_id), 32'(exp_runs));
      check("done_error", 32'(error), 32'(exp_err));
      bad = 1'b0;
      for (int h = 1; h <= int'(HOLDOFF); h++) begin
        tick();
        if (h < int'(HOLDOFF) && (!busy || bus.sink_start || run_done)) bad = 1'b1;
      end
      check("hold_gap", 32'(bad), 32'd0);
      check("hold_exit", 32'(busy), 32'd0);
    end else begin
      done_at = -1;
      while (drain_cyc < 200) begin
        tick();
        drain_cyc++;
        if (run_done) bad = 1'b1;
        if (!busy) begin
          done_at = drain_cyc;
          break;
        end
      end
      exp_err = 1'b1;
      check("timeout_cycles", 32'(done_at), 32'(TIMEOUT));
      check("timeout_no_done", 32'(bad), 32'd0);
      check("timeout_error", 32'(error), 32'd1);
      check("timeout_run_id", 32'(run_id), 32'(exp_runs));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.req          = '0;
    bus.source_valid = 1'b0;
    bus.source_eop   = 1'b0;
    reset            = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    reset = 1'b1;
    repeat (3) tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single requester, full run
    do_run(2'b01, 1'b0, -1, 1'b0);

    // Both requesting continuously: alternation
    for (int r = 0; r < 3; r++) do_run(2'b11, 1'b1, -1, 1'b0);
    bus.req = '0;

    // Random request patterns
    for (int r = 0; r < 2; r++) do_run(2'($urandom_range(1, 3)), 1'b0, -1, 1'b0);

    // Buffer talks during fill: error, run still completes; error stays sticky
    do_run(2'b01, 1'b0, -1, 1'b1);
    do_run(2'($urandom_range(1, 3)), 1'b0, -1, 1'b0);

    // Async reset in the middle of DRAIN
    bus.req = 2'b01;
    tick();
    bus.req = '0;
    repeat (LENGTH + 2) tick();
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    #1;
    reset = 1'b1;
    last_win = NREQ - 1;
    exp_runs = 0;
    exp_err  = 1'b0;
    tick();
    check("post_reset_idle", 32'(busy), 32'd0);

    do_run(2'b10, 1'b0, -1, 1'b0);

    // Drain stalls after two eops: timeout
    do_run(2'($urandom_range(1, 3)), 1'b0, 2, 1'b0);
    tick();
    check("timeout_idle", 32'(busy), 32'd0);
    do_run(2'b11, 1'b0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
